// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: turns the divider's slow square wave into a one-cycle
// tick, steps an off/blink/chase/bounce pattern on it and PWM-gates the LEDs.
module led_pattern_seq #(
  parameter int N_LED    = 8,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                div_clk,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                tick,
  output logic [N_LED-1:0]    led
);

  localparam int POS_W = (N_LED > 2) ? $clog2(N_LED) : 1;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LED - 1);
  localparam logic [N_LED-1:0] ONE_HOT0 = N_LED'(1);

  logic                sync1_q, sync2_q, prev_q, tick_q;
  logic [PWM_BITS-1:0] cnt_q;
  logic [N_LED-1:0]    pattern_q, pattern_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                dir_q, dir_d;
  logic [1:0]          cur_mode_q, cur_mode_d;
  logic [N_LED-1:0]    led_q, led_d;
  logic                rise;
  logic                pwm_on;

  assign rise   = sync2_q & ~prev_q;
  assign pwm_on = (cnt_q < brightness) || (&brightness);

  // A tick with a new mode requested loads that mode's start state instead of stepping.
  always_comb begin
    cur_mode_d = cur_mode_q;
    pattern_d  = pattern_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    if (rise && en) begin
      if (mode != cur_mode_q) begin
        cur_mode_d = mode;
        case (mode)
          MODE_BLINK:  pattern_d = '1;
          MODE_CHASE:  pattern_d = ONE_HOT0;
          MODE_BOUNCE: begin
            pos_d     = '0;
            dir_d     = DIR_UP;
            pattern_d = ONE_HOT0;
          end
          default:     pattern_d = '0;
        endcase
      end else begin
        case (cur_mode_q)
          MODE_BLINK:  pattern_d = ~pattern_q;
          MODE_CHASE:  pattern_d = {pattern_q[N_LED-2:0], pattern_q[N_LED-1]};
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (pos_q == POS_LAST) begin
                dir_d = DIR_DOWN;
                pos_d = pos_q - 1'b1;
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end else if (pos_q == '0) begin
              dir_d = DIR_UP;
              pos_d = pos_q + 1'b1;
            end else begin
              pos_d = pos_q - 1'b1;
            end
            pattern_d = ONE_HOT0 << pos_d;
          end
          default:     pattern_d = '0;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < N_LED; gi++) begin : g_led
    assign led_d[gi] = en & pattern_q[gi] & pwm_on;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      tick_q     <= 1'b0;
      cnt_q      <= '0;
      pattern_q  <= '0;
      pos_q      <= '0;
      dir_q      <= DIR_UP;
      cur_mode_q <= MODE_OFF;
      led_q      <= '0;
    end else begin
      sync1_q    <= div_clk;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      tick_q     <= rise;
      cnt_q      <= cnt_q + 1'b1;
      pattern_q  <= pattern_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      cur_mode_q <= cur_mode_d;
      led_q      <= led_d;
    end
  end

  assign tick = tick_q;
  assign led  = led_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq: directed vector table, corner-case
// sequences and a randomized run against a tick-count based reference model.
module tb_led_pattern_seq;

  localparam int N  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          div_clk;
  logic          en;
  logic [1:0]    mode;
  logic [PW-1:0] brightness;
  logic          tick;
  logic [N-1:0]  led;

  led_pattern_seq #(.N_LED(N), .PWM_BITS(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_clk    (div_clk),
    .en         (en),
    .mode       (mode),
    .brightness (brightness),
    .tick       (tick),
    .led        (led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: the pattern is a pure function of (mode, ticks since load).
  bit           hist[$];
  int unsigned  m_ncyc;
  logic [1:0]   m_mode;
  int           m_k;
  logic         m_tick;
  logic [N-1:0] m_led;

  function automatic logic [N-1:0] pat(input logic [1:0] md, input int k);
    logic [N-1:0] one;
    int p;
    one = {{(N-1){1'b0}}, 1'b1};
    case (md)
      2'd1: return (k % 2 == 0) ? {N{1'b1}} : {N{1'b0}};
      2'd2: return one << (k % N);
      2'd3: begin
        p = k % (2 * (N - 1));
        if (p >= N) p = 2 * (N - 1) - p;
        return one << p;
      end
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    hist   = '{1'b0, 1'b0, 1'b0};
    m_ncyc = 0;
    m_mode = 2'd0;
    m_k    = 0;
    m_tick = 1'b0;
    m_led  = '0;
  endtask

  task automatic model_edge();
    bit rise, pwm;
    rise   = hist[1] & ~hist[0];
    pwm    = ((m_ncyc % (1 << PW)) < brightness) || (brightness == {PW{1'b1}});
    m_led  = en ? (pat(m_mode, m_k) & {N{pwm}}) : '0;
    m_tick = rise;
    if (rise && en) begin
      if (mode != m_mode) begin
        m_mode = mode;
        m_k    = 0;
      end else begin
        m_k++;
      end
    end
    hist.push_back(div_clk);
    void'(hist.pop_front());
    m_ncyc++;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check("tick", tick, m_tick);
    check("led", led, m_led);
  endtask

  int tick_seen;

  task automatic pulse(input string name, input logic [N-1:0] exp);
    tick_seen = 0;
    div_clk = 1'b1;
    repeat (4) begin cyc(); tick_seen += tick; end
    div_clk = 1'b0;
    repeat (4) begin cyc(); tick_seen += tick; end
    check(name, led, exp);
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic         en;
    logic [N-1:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [1:0] md, input logic e, input logic [N-1:0] x);
    vec_t v;
    v.mode = md; v.en = e; v.exp = x;
    vecs.push_back(v);
  endtask

  initial begin
    int off_ticks, on_cnt, hold;

    // Chase continuing after the timing test (which yields 0x01)
    add(2, 1, 8'h02); add(2, 1, 8'h04); add(2, 1, 8'h08); add(2, 1, 8'h10);
    add(2, 1, 8'h20); add(2, 1, 8'h40); add(2, 1, 8'h80); add(2, 1, 8'h01);
    // Bounce, 16 ticks: positions 0..7,6..0,1
    add(3, 1, 8'h01); add(3, 1, 8'h02); add(3, 1, 8'h04); add(3, 1, 8'h08);
    add(3, 1, 8'h10); add(3, 1, 8'h20); add(3, 1, 8'h40); add(3, 1, 8'h80);
    add(3, 1, 8'h40); add(3, 1, 8'h20); add(3, 1, 8'h10); add(3, 1, 8'h08);
    add(3, 1, 8'h04); add(3, 1, 8'h02); add(3, 1, 8'h01); add(3, 1, 8'h02);
    // Blink, then switch to chase
    add(1, 1, 8'hFF); add(1, 1, 8'h00); add(1, 1, 8'hFF); add(2, 1, 8'h01);
    // Chase to 0x04, freeze for 5 ticks, resume
    add(2, 1, 8'h02); add(2, 1, 8'h04);
    add(2, 0, 8'h00); add(2, 0, 8'h00); add(2, 0, 8'h00); add(2, 0, 8'h00); add(2, 0, 8'h00);
    add(2, 1, 8'h08);

    rst = 1'b0; div_clk = 1'b0; en = 1'b0; mode = 2'd0; brightness = '0;
    model_reset();
    #1;
    check("reset_tick", tick, 0);
    check("reset_led", led, 0);
    repeat (3) cyc();
    @(posedge clk); #2; rst = 1'b1;

    // Tick latency: first sampled high at edge k -> tick after edge k+2
    en = 1'b1; mode = 2'd2; brightness = {PW{1'b1}};
    repeat (2) cyc();
    div_clk = 1'b1;
    cyc(); check("tick_k", tick, 0);
    cyc(); check("tick_k1", tick, 0);
    cyc(); check("tick_k2", tick, 1); check("led_k2", led, 0);
    cyc(); check("tick_k3", tick, 0); check("led_k3", led, 8'h01);
    repeat (3) cyc();
    div_clk = 1'b0;
    repeat (4) cyc();

    off_ticks = 0;
    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      en   = vecs[i].en;
      pulse("vec_led", vecs[i].exp);
      if (!vecs[i].en) off_ticks += tick_seen;
      else check("vec_ticks", tick_seen, 1);
    end
    check("en_off_ticks", off_ticks, 5);

    // PWM duty on the frozen 0x08 chase pattern
    brightness = 4'd4;
    on_cnt = 0;
    repeat (16) begin cyc(); on_cnt += led[3]; end
    check("pwm4_duty", on_cnt, 4);
    brightness = 4'd0;
    on_cnt = 0;
    repeat (32) begin cyc(); on_cnt += (led != 0); end
    check("pwm0_off", on_cnt, 0);
    brightness = {PW{1'b1}};
    cyc();

    // Bounce to pos 5 heading down, then asynchronous reset mid-cycle
    mode = 2'd3;
    pulse("bnc_init", 8'h01); pulse("bnc_1", 8'h02); pulse("bnc_2", 8'h04);
    pulse("bnc_3", 8'h08); pulse("bnc_4", 8'h10); pulse("bnc_5", 8'h20);
    pulse("bnc_6", 8'h40); pulse("bnc_7", 8'h80); pulse("bnc_6d", 8'h40);
    pulse("bnc_5d", 8'h20);
    #3; rst = 1'b0;
    #1;
    check("arst_led", led, 0);
    check("arst_tick", tick, 0);
    model_reset();
    repeat (2) cyc();
    @(posedge clk); #2; rst = 1'b1;
    pulse("post_rst_0", 8'h01);
    pulse("post_rst_up", 8'h02);

    // Randomized run against the model
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        div_clk = ~div_clk;
        hold = $urandom_range(1, 6);
      end
      hold--;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 31) == 0) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) brightness = PW'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
